// File: rtl/digit_loader_ctrl.sv
// Digit loader sequencer: edits a BCD value one digit at a time from debounced buttons, then commits it through a valid/ack handshake.
// Optional AUTO_REPEAT_EN adds hold-to-repeat stepping on inc/dec.
module digit_loader_ctrl #(
  parameter int DIGITS        = 4,
  parameter int MAX_DIGIT     = 9,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                                   clk,
  input  logic                                   sync_nreset,
  input  logic                                   btn_inc,
  input  logic                                   btn_dec,
  input  logic                                   btn_next,
  input  logic                                   btn_load,
  input  logic                                   value_ack,
  output logic                                   editing,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] edit_index,
  output logic [4*DIGITS-1:0]                    edit_value,
  output logic [4*DIGITS-1:0]                    value_out,
  output logic                                   value_valid
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [3:0]    MAXD = 4'(MAX_DIGIT);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

  state_t        r_state;
  logic          r_editing, r_valid;
  logic [IW-1:0] r_idx;
  logic [VW-1:0] r_edit_value, r_value_out;
  logic          r_prev_inc, r_prev_dec, r_prev_next, r_prev_load;

  logic          w_inc_e, w_dec_e, w_next_e, w_load_e;
  logic          w_rep_up, w_rep_dn, w_up, w_dn;
  logic [VW-1:0] w_new_value;

  assign w_inc_e  = btn_inc  & ~r_prev_inc;
  assign w_dec_e  = btn_dec  & ~r_prev_dec;
  assign w_next_e = btn_next & ~r_prev_next;
  assign w_load_e = btn_load & ~r_prev_load;

`ifdef AUTO_REPEAT_EN
  logic [31:0] r_rep_cnt;
  logic        r_rep_phase;
  logic        w_rep_run, w_rep_fire;

  // Counter runs only while exactly one direction is held in EDIT; phase selects first-delay vs period.
  assign w_rep_run  = (r_state == S_EDIT) && (btn_inc ^ btn_dec) && !w_load_e;
  assign w_rep_fire = w_rep_run &&
                      (r_rep_cnt == (r_rep_phase ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY)));
  assign w_rep_up   = w_rep_fire & btn_inc;
  assign w_rep_dn   = w_rep_fire & btn_dec;

  always_ff @(posedge clk) begin
    if (!sync_nreset || !w_rep_run) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= 32'd1;
      r_rep_phase <= 1'b1;
    end else begin
      r_rep_cnt   <= r_rep_cnt + 32'd1;
    end
  end
`else
  logic [31:0] w_unused_rep;
  assign w_unused_rep = 32'(REPEAT_DELAY) ^ 32'(REPEAT_PERIOD);
  assign w_rep_up = 1'b0;
  assign w_rep_dn = 1'b0;
`endif

  // Simultaneous inc and dec edges cancel.
  assign w_up = (w_inc_e & ~w_dec_e) | w_rep_up;
  assign w_dn = (w_dec_e & ~w_inc_e) | w_rep_dn;

  always_comb begin
    w_new_value = r_edit_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == r_idx) begin
        if (w_up)
          w_new_value[4*i +: 4] = (r_edit_value[4*i +: 4] >= MAXD) ? 4'd0
                                                                    : r_edit_value[4*i +: 4] + 4'd1;
        else if (w_dn)
          w_new_value[4*i +: 4] = (r_edit_value[4*i +: 4] == 4'd0) ? MAXD
                                                                    : r_edit_value[4*i +: 4] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      r_state      <= S_IDLE;
      r_editing    <= 1'b0;
      r_valid      <= 1'b0;
      r_idx        <= '0;
      r_edit_value <= '0;
      r_value_out  <= '0;
      // Prev at 1 so a button held through reset yields no edge.
      r_prev_inc   <= 1'b1;
      r_prev_dec   <= 1'b1;
      r_prev_next  <= 1'b1;
      r_prev_load  <= 1'b1;
    end else begin
      r_prev_inc   <= btn_inc;
      r_prev_dec   <= btn_dec;
      r_prev_next  <= btn_next;
      r_prev_load  <= btn_load;
      case (r_state)
        S_IDLE: begin
          if (w_load_e) begin
            r_state      <= S_EDIT;
            r_editing    <= 1'b1;
            r_edit_value <= r_value_out;
            r_idx        <= '0;
          end
        end
        S_EDIT: begin
          if (w_load_e) begin
            r_state     <= S_COMMIT;
            r_editing   <= 1'b0;
            r_value_out <= r_edit_value;
            r_valid     <= 1'b1;
          end else begin
            // Digit change uses the old index; index advance lands afterwards.
            r_edit_value <= w_new_value;
            if (w_next_e)
              r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
          end
        end
        S_COMMIT: begin
          if (value_ack) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_editing <= 1'b0;
          r_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign editing     = r_editing;
  assign edit_index  = r_idx;
  assign edit_value  = r_edit_value;
  assign value_out   = r_value_out;
  assign value_valid = r_valid;
endmodule

// File: tb/tb_digit_loader_ctrl.sv
// Directed bench for digit_loader_ctrl (DIGITS=4, MAX_DIGIT=9, short repeat timing); expectations follow AUTO_REPEAT_EN.
module tb_digit_loader_ctrl;
  logic        clk = 1'b0;
  logic        sync_nreset = 1'b0;
  logic        btn_inc = 1'b0, btn_dec = 1'b0, btn_next = 1'b0, btn_load = 1'b0;
  logic        value_ack = 1'b0;
  logic        editing;
  logic [1:0]  edit_index;
  logic [15:0] edit_value, value_out;
  logic        value_valid;

  int total = 0;
  int bad   = 0;

  digit_loader_ctrl #(.DIGITS(4), .MAX_DIGIT(9), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut (
    .clk(clk), .sync_nreset(sync_nreset),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_next(btn_next), .btn_load(btn_load),
    .value_ack(value_ack),
    .editing(editing), .edit_index(edit_index), .edit_value(edit_value),
    .value_out(value_out), .value_valid(value_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic i, input logic d, input logic n, input logic l);
    btn_inc = i; btn_dec = d; btn_next = n; btn_load = l;
    step(1);
    btn_inc = 0; btn_dec = 0; btn_next = 0; btn_load = 0;
    step(1);
  endtask

  initial begin
    int vcnt;
    // Reset with inc held, then keep holding after release
    btn_inc = 1;
    step(3);
    chk("rst_editing", 32'(editing), 0);
    chk("rst_index", 32'(edit_index), 0);
    chk("rst_value", 32'(edit_value), 0);
    chk("rst_out", 32'(value_out), 0);
    chk("rst_valid", 32'(value_valid), 0);
    sync_nreset = 1;
    step(10);
    chk("held_value", 32'(edit_value), 0);
    chk("held_editing", 32'(editing), 0);
    btn_inc = 0;
    step(1);

    // Enter edit
    press(0, 0, 0, 1);
    chk("enter_editing", 32'(editing), 1);
    chk("enter_index", 32'(edit_index), 0);
    repeat (3) press(1, 0, 0, 0);
    chk("inc3", 32'(edit_value), 32'h0003);
    press(0, 0, 1, 0);
    chk("next_index", 32'(edit_index), 1);
    press(0, 1, 0, 0);
    chk("dec_wrap", 32'(edit_value), 32'h0093);
    repeat (9) press(0, 1, 0, 0);
    chk("dec10", 32'(edit_value), 32'h0003);
    chk("dec10_index", 32'(edit_index), 1);

    // Digit3 = 9, then inc+next together at index 3
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    chk("idx3", 32'(edit_index), 3);
    press(0, 1, 0, 0);
    chk("d3_nine", 32'(edit_value), 32'h9003);
    press(1, 0, 1, 0);
    chk("incnext_val", 32'(edit_value), 32'h0003);
    chk("incnext_idx", 32'(edit_index), 0);
    press(1, 1, 0, 0);
    chk("incdec_cancel", 32'(edit_value), 32'h0003);
    press(1, 0, 0, 0);
    chk("inc_d0", 32'(edit_value), 32'h0004);

    // Commit with ack held low for 20 cycles while buttons toggle
    btn_load = 1;
    step(1);
    btn_load = 0;
    vcnt = value_valid ? 1 : 0;
    chk("commit_out", 32'(value_out), 32'h0004);
    chk("commit_editing", 32'(editing), 0);
    for (int i = 0; i < 19; i++) begin
      btn_inc = (i % 2 == 0); btn_next = (i % 3 == 0); btn_load = (i % 4 == 1);
      step(1);
      if (value_valid) vcnt++;
    end
    btn_inc = 0; btn_next = 0; btn_load = 0;
    chk("valid_20", 32'(vcnt), 20);
    chk("commit_hold_out", 32'(value_out), 32'h0004);
    chk("commit_hold_edit", 32'(edit_value), 32'h0004);
    value_ack = 1;
    step(1);
    value_ack = 0;
    chk("ack_valid", 32'(value_valid), 0);
    chk("ack_editing", 32'(editing), 0);

    // IDLE ignores inc; re-enter; load+inc together commits old value
    press(1, 0, 0, 0);
    chk("idle_inc", 32'(edit_value), 32'h0004);
    press(0, 0, 0, 1);
    chk("reenter", 32'(editing), 1);
    press(1, 0, 0, 1);
    chk("ldinc_valid", 32'(value_valid), 1);
    chk("ldinc_out", 32'(value_out), 32'h0004);
    chk("ldinc_edit", 32'(edit_value), 32'h0004);
    value_ack = 1;
    step(1);
    value_ack = 0;
    chk("ldinc_ack", 32'(value_valid), 0);

    // Ack already high on commit entry: valid lasts one cycle
    press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    chk("pre_ack_edit", 32'(edit_value), 32'h0005);
    value_ack = 1;
    btn_load = 1;
    step(1);
    btn_load = 0;
    chk("fast_valid", 32'(value_valid), 1);
    chk("fast_out", 32'(value_out), 32'h0005);
    step(1);
    value_ack = 0;
    chk("fast_done", 32'(value_valid), 0);

    // Hold inc on digit1
    press(0, 0, 0, 1);
    press(0, 0, 1, 0);
    btn_inc = 1;
    step(1);
    chk("rep_edge", 32'(edit_value), 32'h0015);
    step(9);
    chk("rep_9", 32'(edit_value), 32'h0015);
`ifdef AUTO_REPEAT_EN
    step(1);  chk("rep_10", 32'(edit_value), 32'h0025);
    step(4);  chk("rep_14", 32'(edit_value), 32'h0035);
    step(4);  chk("rep_18", 32'(edit_value), 32'h0045);
    step(4);  chk("rep_22", 32'(edit_value), 32'h0055);
`else
    step(1);  chk("rep_10", 32'(edit_value), 32'h0015);
    step(12); chk("rep_22", 32'(edit_value), 32'h0015);
`endif
    btn_inc = 0;
    step(1);

    // Reset during handshake
    press(0, 0, 0, 1);
    chk("pre_rst_valid", 32'(value_valid), 1);
    sync_nreset = 0;
    step(1);
    chk("mid_rst_valid", 32'(value_valid), 0);
    chk("mid_rst_out", 32'(value_out), 0);
    chk("mid_rst_edit", 32'(edit_value), 0);
    sync_nreset = 1;
    step(2);
    chk("post_rst_valid", 32'(value_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
